// File: rtl/key_press_conditioner_if.sv
// Button-pin bundle between board keys and key_press_conditioner.
// master drives the raw pins; slave is the conditioner itself.
interface key_press_conditioner_if #(
  parameter int unsigned NUM_KEYS = 4
);
  localparam int unsigned OwnerW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [OwnerW-1:0]   owner;
  logic                busy;

  modport master (
    output key_raw,
    input  key_level,
    input  key_pulse,
    input  owner,
    input  busy
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_pulse,
    output owner,
    output busy
  );
endinterface

// File: rtl/key_press_conditioner.sv
// Push-button front end: synchroniser, debounce, single-owner arbitration, press strobes.
// Optional auto-repeat while held is built when KEY_COND_AUTOREPEAT_EN is defined.
module key_press_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ACTIVE_LOW_KEYS = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic                    clock,
  input logic                    reset_n,
  key_press_conditioner_if.slave keys
);

  localparam int unsigned OwnerW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned MaxA     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                       : REPEAT_DELAY;
  localparam int unsigned MaxCount = (MaxA > REPEAT_PERIOD) ? MaxA : REPEAT_PERIOD;
  localparam int unsigned CntW     = $clog2(MaxCount + 1);

  localparam logic [CntW-1:0]     DbLimit     = CntW'(DEBOUNCE_CYCLES);
  localparam logic [NUM_KEYS-1:0] ReleasedLvl = (ACTIVE_LOW_KEYS != 0) ? '1 : '0;

  typedef enum logic [1:0] {StIdle, StDbPress, StHeld, StDbRelease} state_e;

  state_e              state_q, state_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] kp;
  logic [OwnerW-1:0]   first_idx;

`ifdef KEY_COND_AUTOREPEAT_EN
  localparam logic [CntW-1:0] RptDelay  = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] RptPeriod = CntW'(REPEAT_PERIOD);

  logic [CntW-1:0] rpt_q, rpt_d, rpt_inc;
  logic            period_q, period_d;
`endif

  // Reset loads the released level so leaving reset never looks like a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= ReleasedLvl;
    end else begin
      sync_q[0] <= keys.key_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign kp = (ACTIVE_LOW_KEYS != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  always_comb begin
    first_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (kp[i]) first_idx = OwnerW'(i);
    end
  end

  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    level_d = '0;
`ifdef KEY_COND_AUTOREPEAT_EN
    rpt_d    = rpt_q;
    period_d = period_q;
    rpt_inc  = (rpt_q == {CntW{1'b1}}) ? rpt_q : rpt_q + 1'b1;
`endif
    unique case (state_q)
      StIdle: begin
        if (|kp) begin
          owner_d = first_idx;
          cnt_d   = CntW'(1);
          state_d = StDbPress;
        end
      end
      StDbPress: begin
        if (!kp[owner_q]) begin
          state_d = StIdle;
        end else if (cnt_q >= DbLimit) begin
          state_d          = StHeld;
          cnt_d            = '0;
          pulse_d[owner_q] = 1'b1;
`ifdef KEY_COND_AUTOREPEAT_EN
          rpt_d    = '0;
          period_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        if (!kp[owner_q]) begin
          state_d = StDbRelease;
          cnt_d   = CntW'(1);
        end
`ifdef KEY_COND_AUTOREPEAT_EN
        // rpt_q is the held-cycle count since the last strobe; it freezes in StDbRelease.
        else if (rpt_inc == (period_q ? RptPeriod : RptDelay)) begin
          pulse_d[owner_q] = 1'b1;
          rpt_d            = '0;
          period_d         = 1'b1;
        end else begin
          rpt_d = rpt_inc;
        end
`endif
      end
      StDbRelease: begin
        if (kp[owner_q]) begin
          state_d = StHeld;
        end else if (cnt_q >= DbLimit) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StHeld || state_d == StDbRelease) level_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

`ifdef KEY_COND_AUTOREPEAT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_q    <= '0;
      period_q <= 1'b0;
    end else begin
      rpt_q    <= rpt_d;
      period_q <= period_d;
    end
  end
`endif

  assign keys.key_pulse = pulse_q;
  assign keys.key_level = level_q;
  assign keys.owner     = owner_q;
  assign keys.busy      = (state_q != StIdle);

endmodule
